// File: rtl/overdrive_pkg.sv
// overdrive_pkg: shared sample type, scheduler states and clip limits for the overdrive scheduler.
package overdrive_pkg;
  typedef logic signed [15:0] sample_t;
  typedef enum logic [1:0] {IDLE, RUN_L, RUN_R} sched_state_t;
  localparam int CLIP_LO_GAIN = 10000;
  localparam int CLIP_HI_GAIN = 15000;
endpackage

// File: rtl/overdrive_scheduler_debounce.sv
// footswitch_debounce: 2-FF synchronizer plus stability counter; pulses rise_o when the accepted level rises.
module footswitch_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o
);
  localparam int CW = $clog2(CYCLES);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic level_q;
  logic done;
  assign done = cnt_q == CW'(CYCLES - 1);
  // The counter only runs while the synced level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      rise_o <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (done) begin
        cnt_q <= '0;
        level_q <= sync_q[1];
        rise_o <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/overdrive_scheduler.sv
// overdrive_scheduler: time-shares one clipping datapath between left/right per frame; debounced gain/bypass toggles.
// Optional OVERDRIVE_SCHED_OVERRUN_CNT_EN adds a saturating dropped-frame counter output.
module overdrive_scheduler
  import overdrive_pkg::*;
#(
  parameter int DW = 16,
  parameter int DP_LATENCY = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          frame_strobe,
  input  logic [DW-1:0] in_left,
  input  logic [DW-1:0] in_right,
  input  logic          fsw_gain_raw,
  input  logic          fsw_bypass_raw,
  input  logic          overrun_clr,
  output logic [DW-1:0] fx_in,
  output logic          fx_gain,
  input  logic [DW-1:0] fx_result,
  output logic [DW-1:0] out_left,
  output logic [DW-1:0] out_right,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
`ifdef OVERDRIVE_SCHED_OVERRUN_CNT_EN
  output logic [7:0]    overrun_count,
`endif
  output logic          gain_sel,
  output logic          bypass_sel
);
  sched_state_t state_q;
  logic [2:0] wait_q;
  logic [DW-1:0] right_q;
  logic bypass_q;
  logic gain_rise, bypass_rise, last, drop;
  assign busy = state_q != IDLE;
  assign last = wait_q == 3'(DP_LATENCY);
  assign drop = frame_strobe & busy;

  footswitch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_gain_db (
    .clk(CLK), .rst_n(RESET_N), .raw_i(fsw_gain_raw), .rise_o(gain_rise)
  );
  footswitch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_bypass_db (
    .clk(CLK), .rst_n(RESET_N), .raw_i(fsw_bypass_raw), .rise_o(bypass_rise)
  );

  // fx_in holds the sample being processed, so it doubles as the bypass source.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      wait_q <= '0;
      right_q <= '0;
      bypass_q <= 1'b0;
      fx_in <= '0;
      fx_gain <= 1'b0;
      out_left <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
      gain_sel <= 1'b0;
      bypass_sel <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun <= drop | (overrun & ~overrun_clr);
      gain_sel <= gain_sel ^ gain_rise;
      bypass_sel <= bypass_sel ^ bypass_rise;
      case (state_q)
        IDLE: if (frame_strobe) begin
          fx_in <= in_left;
          right_q <= in_right;
          fx_gain <= gain_sel;
          bypass_q <= bypass_sel;
          wait_q <= '0;
          state_q <= RUN_L;
        end
        RUN_L: if (last) begin
          out_left <= bypass_q ? fx_in : fx_result;
          fx_in <= right_q;
          wait_q <= '0;
          state_q <= RUN_R;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
        RUN_R: if (last) begin
          out_right <= bypass_q ? fx_in : fx_result;
          out_valid <= 1'b1;
          state_q <= IDLE;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OVERDRIVE_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) overrun_count <= '0;
    else overrun_count <= overrun_clr ? 8'd0 : (drop && overrun_count != 8'hff) ? overrun_count + 8'd1 : overrun_count;
  end
`endif
endmodule

// File: tb/tb_overdrive_scheduler.sv
// tb_overdrive_scheduler: directed frames with a clipping datapath model; expected pairs queued and checked by a monitor.
module tb_overdrive_scheduler;
  import overdrive_pkg::*;
  localparam int DW = 16;
  logic CLK = 1'b0, RESET_N = 1'b0, frame_strobe = 1'b0, fsw_gain_raw = 1'b0, fsw_bypass_raw = 1'b0, overrun_clr = 1'b0;
  sample_t in_left = '0, in_right = '0, fx_result = '0;
  logic [DW-1:0] fx_in, out_left, out_right;
  logic fx_gain, out_valid, busy, overrun, gain_sel, bypass_sel;
`ifdef OVERDRIVE_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_count;
`endif
  int checks = 0, failures = 0, n_valid = 0;
  logic [31:0] exp_q[$];

  overdrive_scheduler #(.DW(DW), .DP_LATENCY(1), .DEBOUNCE_CYCLES(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .frame_strobe(frame_strobe), .in_left(in_left), .in_right(in_right),
    .fsw_gain_raw(fsw_gain_raw), .fsw_bypass_raw(fsw_bypass_raw), .overrun_clr(overrun_clr),
    .fx_in(fx_in), .fx_gain(fx_gain), .fx_result(fx_result), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .busy(busy), .overrun(overrun),
`ifdef OVERDRIVE_SCHED_OVERRUN_CNT_EN
    .overrun_count(overrun_count),
`endif
    .gain_sel(gain_sel), .bypass_sel(bypass_sel)
  );

  always #5 CLK = ~CLK;

  function automatic sample_t clip(sample_t x, logic g);
    int lim = g ? CLIP_HI_GAIN : CLIP_LO_GAIN;
    int xi = x;
    return sample_t'(xi > lim ? lim : xi < -lim ? -lim : xi);
  endfunction

  always @(posedge CLK) fx_result <= clip(fx_in, fx_gain);

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) if (RESET_N && out_valid) begin
    n_valid++;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: got out_valid with L=%0h R=%0h, none expected", out_left, out_right);
    end else begin
      chk("sb_pair", {out_left, out_right}, exp_q.pop_front());
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic run_frame(sample_t l, sample_t r, sample_t el, sample_t er);
    exp_q.push_back({el, er});
    in_left = l; in_right = r; frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("busy_window", {31'd0, busy}, 32'd1);
      chk("no_early_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("valid_t5", {31'd0, out_valid}, 32'd1);
    chk("idle_t5", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tick(2);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_leds", {30'd0, gain_sel, bypass_sel}, 32'd0);
    chk("rst_data", {out_left, fx_in}, 32'd0);
    RESET_N = 1'b1;
    tick(2);
    run_frame(20000, -5000, 10000, -5000);
    // Gain toggles while the frame is in flight: that frame keeps gain 0.
    fsw_gain_raw = 1'b1;
    tick(16);
    run_frame(-20000, 12000, -10000, 10000);
    chk("gain_on", {31'd0, gain_sel}, 32'd1);
    run_frame(-20000, 12000, -15000, 12000);
    fsw_gain_raw = 1'b0;
    tick(30);
    chk("gain_release", {31'd0, gain_sel}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      fsw_gain_raw = ~fsw_gain_raw;
      tick(5);
    end
    tick(30);
    chk("chatter", {31'd0, gain_sel}, 32'd1);
    fsw_bypass_raw = 1'b1;
    tick(25);
    fsw_bypass_raw = 1'b0;
    tick(25);
    chk("bypass_on", {31'd0, bypass_sel}, 32'd1);
    run_frame(30000, -30000, 30000, -30000);
    exp_q.push_back({16'sd100, -16'sd100});
    in_left = 100; in_right = -100; frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    tick();
    in_left = 5; in_right = 5; frame_strobe = 1'b1; overrun_clr = 1'b1;
    tick();
    frame_strobe = 1'b0; overrun_clr = 1'b0;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("busy_t3", {31'd0, busy}, 32'd1);
    tick(2);
    chk("valid_after_drop", {31'd0, out_valid}, 32'd1);
    exp_q.push_back({16'sd7, 16'sd8});
    in_left = 7; in_right = 8; frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    chk("accept_in_valid_cycle", {31'd0, busy}, 32'd1);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    tick(4);
    chk("valid_second", {31'd0, out_valid}, 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("overrun_clr", {31'd0, overrun}, 32'd0);
    in_left = 1; in_right = 2; frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    tick(2);
    RESET_N = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_outs", {out_left, out_right}, 32'd0);
    chk("arst_fx", {15'd0, fx_gain, fx_in}, 32'd0);
    chk("arst_leds", {29'd0, out_valid, gain_sel, bypass_sel}, 32'd0);
    tick();
    RESET_N = 1'b1;
    tick(10);
`ifdef OVERDRIVE_SCHED_OVERRUN_CNT_EN
    for (int i = 0; i < 80; i++) exp_q.push_back(32'd0);
    in_left = 0; in_right = 0; frame_strobe = 1'b1;
    tick(400);
    frame_strobe = 1'b0;
    chk("ovc_sat", {24'd0, overrun_count}, 32'd255);
    tick(6);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovc_clr", {24'd0, overrun_count}, 32'd0);
`endif
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
